ei_axi4_wr_master: RTL and testbench

EI_AXI4_WR_MASTER -- requirements
Module: ei_axi4_wr_master

---
 rtl/ei_axi4_wr_master.sv | 156 +++++++++++++++
 tb/tb_ei_axi4_wr_master.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ei_axi4_wr_master.sv
// Single-outstanding AXI4 write-burst master: command in, AW then W then B, one-cycle completion pulse.
// Optional B-channel watchdog enabled by defining EI_AXI4_WR_TIMEOUT_EN.
module ei_axi4_wr_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [2:0]              cmd_size,
  input  logic [1:0]              cmd_burst,
  input  logic                    wd_valid,
  output logic                    wd_ready,
  input  logic [DATA_WIDTH-1:0]   wd_data,
  input  logic [DATA_WIDTH/8-1:0] wd_strb,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic                    rsp_valid,
  output logic [1:0]              rsp_resp,
  output logic                    timeout_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q;
  logic [7:0]              awlen_q;
  logic [2:0]              awsize_q;
  logic [1:0]              awburst_q;
  logic [7:0]              beat_q, beat_d;
  logic                    live_q;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [1:0]              rsp_resp_q, rsp_resp_d;
  logic                    cmd_fire;

  // live_q keeps cmd_ready low until the first edge after reset release
  assign cmd_ready = (state_q == IDLE) && live_q;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign awvalid   = (state_q == ADDR);
  assign wvalid    = (state_q == DATA) && wd_valid;
  assign wd_ready  = (state_q == DATA) && wready;
  assign wdata     = wd_data;
  assign wstrb     = wd_strb;
  assign wlast     = (state_q == DATA) && (beat_q == awlen_q);
  assign bready    = (state_q == RESP);
  assign awaddr    = awaddr_q;
  assign awlen     = awlen_q;
  assign awsize    = awsize_q;
  assign awburst   = awburst_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_resp  = rsp_resp_q;

`ifdef EI_AXI4_WR_TIMEOUT_EN
  logic [7:0] wdog_q, wdog_d;
  logic       tmo_q, tmo_d;
  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    rsp_valid_d = 1'b0;
    rsp_resp_d  = rsp_resp_q;
`ifdef EI_AXI4_WR_TIMEOUT_EN
    wdog_d      = 8'd0;
    tmo_d       = 1'b0;
`endif
    case (state_q)
      IDLE: if (cmd_fire) state_d = ADDR;
      ADDR: if (awready) begin
        state_d = DATA;
        beat_d  = 8'd0;
      end
      DATA: if (wvalid && wready) begin
        beat_d = beat_q + 8'd1;
        if (wlast) state_d = RESP;
      end
      RESP: begin
        if (bvalid) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = bresp;
        end
`ifdef EI_AXI4_WR_TIMEOUT_EN
        // wdog_q==255 means this is the 256th RESP cycle without bvalid
        else if (wdog_q == 8'hFF) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = 2'd2;
          tmo_d       = 1'b1;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      beat_q      <= 8'd0;
      live_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_resp_q  <= 2'd0;
      awaddr_q    <= '0;
      awlen_q     <= 8'd0;
      awsize_q    <= 3'd0;
      awburst_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      live_q      <= 1'b1;
      rsp_valid_q <= rsp_valid_d;
      rsp_resp_q  <= rsp_resp_d;
      // burst type passes through untouched, including the reserved encoding
      if (cmd_fire) begin
        awaddr_q  <= cmd_addr;
        awlen_q   <= cmd_len;
        awsize_q  <= cmd_size;
        awburst_q <= cmd_burst;
      end
    end
  end

`ifdef EI_AXI4_WR_TIMEOUT_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wdog_q <= 8'd0;
      tmo_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      tmo_q  <= tmo_d;
    end
  end
`endif

endmodule

// File: tb/tb_ei_axi4_wr_master.sv
// Scoreboard bench for ei_axi4_wr_master: directed bursts, expected AW/W/response records queued at issue.
module tb_ei_axi4_wr_master;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [2:0]    cmd_size;
  logic [1:0]    cmd_burst;
  logic          wd_valid, wd_ready;
  logic [DW-1:0] wd_data;
  logic [3:0]    wd_strb;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awvalid, awready;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          wlast, wvalid, wready;
  logic [1:0]    bresp;
  logic          bvalid, bready;
  logic          rsp_valid;
  logic [1:0]    rsp_resp;
  logic          timeout_err;

  always #5 aclk = ~aclk;

  ei_axi4_wr_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .rsp_valid(rsp_valid), .rsp_resp(rsp_resp), .timeout_err(timeout_err)
  );

  typedef struct packed {logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst;} aw_t;
  typedef struct packed {logic [31:0] data; logic [3:0] strb; logic last;} w_t;
  typedef struct packed {logic [1:0] resp; logic tmo;} r_t;

  aw_t aw_q[$];
  w_t  w_q[$];
  r_t  r_q[$];
  int  checks = 0;
  int  failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dat(input logic [31:0] a, input int i);
    return {a[15:0], 8'hC0, 8'(i)};
  endfunction

  function automatic logic [3:0] stb(input int i);
    logic [3:0] s;
    s = 4'hF;
    return s >> (i % 4);
  endfunction

  // Monitor: pops expected records whenever the DUT presents a transfer
  aw_t m_aw;
  w_t  m_w;
  r_t  m_r;
  logic prev_rsp = 1'b0;
  always @(negedge aclk) begin
    if (aresetn) begin
      if (awvalid && awready) begin
        if (aw_q.size() == 0) chk("aw_unexpected", 1, 0);
        else begin
          m_aw = aw_q.pop_front();
          chk("awaddr", awaddr, m_aw.addr);
          chk("awlen", awlen, m_aw.len);
          chk("awsize", awsize, m_aw.size);
          chk("awburst", awburst, m_aw.burst);
        end
      end
      if (wvalid && wready) begin
        if (w_q.size() == 0) chk("w_unexpected", 1, 0);
        else begin
          m_w = w_q.pop_front();
          chk("wdata", wdata, m_w.data);
          chk("wstrb", wstrb, m_w.strb);
          chk("wlast", wlast, m_w.last);
        end
      end
      if (rsp_valid) begin
        chk("rsp_cmd_ready", cmd_ready, 1);
        chk("rsp_double", prev_rsp, 0);
        if (r_q.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          m_r = r_q.pop_front();
          chk("rsp_resp", rsp_resp, m_r.resp);
          chk("timeout_err", timeout_err, m_r.tmo);
        end
      end else if (timeout_err) chk("tmo_stray", timeout_err, 0);
      if (cmd_ready && (awvalid || bready)) chk("cmd_ready_excl", 1, 0);
      prev_rsp = rsp_valid;
    end else prev_rsp = 1'b0;
  end

  task automatic burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                       input logic [1:0] bt, input logic [1:0] resp, input int aw_dly,
                       input bit wtog, input int b_dly, input bit tmo, input int abort_at);
    aw_t e;
    w_t  w;
    r_t  r;
    int  n;
    int  i;
    e.addr = addr; e.len = len; e.size = size; e.burst = bt;
    aw_q.push_back(e);
    for (int k = 0; k <= int'(len); k++) begin
      w.data = dat(addr, k); w.strb = stb(k); w.last = (k == int'(len));
      w_q.push_back(w);
    end
    r.resp = tmo ? 2'd2 : resp; r.tmo = tmo;
    r_q.push_back(r);

    @(posedge aclk); #1;
    cmd_valid = 1; cmd_addr = addr; cmd_len = len; cmd_size = size; cmd_burst = bt;
    wd_valid = 1; wd_data = dat(addr, 0); wd_strb = stb(0);
    n = 0;
    do begin @(negedge aclk); n++; end while (!cmd_ready && n < 50);
    if (!cmd_ready) chk("cmd_ready_wait", 0, 1);
    @(posedge aclk); #1;
    cmd_valid = 0; cmd_addr = 32'hDEAD_BEEF; cmd_len = 8'hEE; cmd_burst = 2'd0;
    for (int k = 0; k < aw_dly; k++) begin
      @(negedge aclk);
      chk("awvalid_hold", awvalid, 1);
      chk("awaddr_stable", awaddr, addr);
      chk("awlen_stable", awlen, len);
      chk("no_w_before_aw", wvalid, 0);
      @(posedge aclk); #1;
    end
    awready = 1;
    @(negedge aclk);
    chk("awvalid_last", awvalid, 1);
    chk("no_w_at_aw", wvalid, 0);
    @(posedge aclk); #1;
    awready = 0;

    i = 0; n = 0;
    while (i <= int'(len) && n < 200) begin
      if (i == abort_at) begin
        aresetn = 0;
        #1;
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_wd_ready", wd_ready, 0);
        chk("rst_bready", bready, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        w_q.delete(); r_q.delete();
        wd_valid = 0; wready = 0;
        repeat (2) begin @(negedge aclk); chk("rst_no_rsp", rsp_valid, 0); end
        aresetn = 1;
        #1 chk("rst_rel_cmd_ready", cmd_ready, 0);
        @(posedge aclk); #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_rsp", rsp_valid, 0);
        return;
      end
      wready = wtog ? (n % 2 == 0) : 1'b1;
      wd_data = dat(addr, i); wd_strb = stb(i);
      @(negedge aclk);
      if (n == 0) chk("awvalid_drop", awvalid, 0);
      if (wvalid && wready) i++;
      @(posedge aclk); #1;
      n++;
    end
    wready = 0; wd_valid = 0;
    if (i <= int'(len)) chk("w_beats_timeout", i, int'(len) + 1);
    bresp = resp;

    if (tmo) begin
      n = 0;
      while (n <= 300) begin
        @(negedge aclk);
        if (rsp_valid) break;
        if (bready) n++;
      end
      chk("tmo_latency", n, 256);
      @(negedge aclk);
      chk("tmo_single", rsp_valid, 0);
      chk("tmo_hold", rsp_resp, 2);
    end else begin
      for (int k = 0; k < b_dly; k++) begin
        @(negedge aclk);
        chk("bready_wait", bready, 1);
        chk("no_early_rsp", rsp_valid, 0);
        @(posedge aclk); #1;
      end
      bvalid = 1;
      @(negedge aclk);
      chk("bready_hs", bready, 1);
      @(posedge aclk); #1;
      bvalid = 0;
      @(negedge aclk);
      chk("rsp_pulse", rsp_valid, 1);
      @(negedge aclk);
      chk("rsp_single", rsp_valid, 0);
      chk("bready_off", bready, 0);
      chk("rsp_hold", rsp_resp, resp);
    end
  endtask

  initial begin
    aresetn = 0;
    cmd_valid = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0; cmd_burst = 0;
    wd_valid = 0; wd_data = 0; wd_strb = 0;
    awready = 0; wready = 0; bresp = 0; bvalid = 0;
    // bvalid outside RESP must be ignored
    repeat (3) @(negedge aclk);
    chk("rst_state_awvalid", awvalid, 0);
    chk("rst_state_wvalid", wvalid, 0);
    chk("rst_state_bready", bready, 0);
    chk("rst_state_cmd_ready", cmd_ready, 0);
    chk("rst_state_rsp", {rsp_valid, rsp_resp, timeout_err}, 0);
    chk("rst_state_aw", {awaddr, awlen, awsize, awburst}, 0);
    aresetn = 1;
    @(posedge aclk); #1;
    chk("idle_cmd_ready", cmd_ready, 1);
    bvalid = 1; bresp = 2'd3;
    @(negedge aclk);
    chk("idle_bvalid_ignored", {bready, rsp_valid}, 0);
    @(posedge aclk); #1;
    bvalid = 0;

    burst(32'h0000_1000, 8'd0,  3'd2, 2'd1, 2'd0, 0, 0, 0,  0, -1);
    burst(32'h0000_2000, 8'd7,  3'd2, 2'd1, 2'd0, 0, 1, 0,  0, -1);
    burst(32'h0000_3004, 8'd3,  3'd2, 2'd2, 2'd0, 5, 0, 0,  0, -1);
    burst(32'h0000_5000, 8'd1,  3'd1, 2'd0, 2'd2, 0, 0, 10, 0, -1);
    burst(32'h0000_6008, 8'd2,  3'd0, 2'd3, 2'd3, 1, 1, 2,  0, -1);
    burst(32'h0000_4000, 8'd15, 3'd2, 2'd1, 2'd0, 0, 0, 0,  0, 3);
    burst(32'h0000_7000, 8'd1,  3'd2, 2'd1, 2'd0, 0, 0, 0,  0, -1);
`ifdef EI_AXI4_WR_TIMEOUT_EN
    burst(32'h0000_8000, 8'd0,  3'd2, 2'd1, 2'd0, 0, 0, 0,  1, -1);
`else
    burst(32'h0000_8000, 8'd0,  3'd2, 2'd1, 2'd1, 0, 0, 300, 0, -1);
`endif
    burst(32'h0000_9000, 8'd2,  3'd2, 2'd1, 2'd1, 2, 1, 1,  0, -1);

    repeat (3) @(negedge aclk);
    chk("aw_q_empty", aw_q.size(), 0);
    chk("w_q_empty", w_q.size(), 0);
    chk("r_q_empty", r_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end
endmodule
